// File: rtl/ise_pkg.sv
// Shared definitions for the Image Sorting Engine front end.
// Holds the image geometry, counter/index widths, the dominant-colour
// encoding and the classifier FSM state type.
package ise_pkg;

  localparam int unsigned IMAGE_SIZE  = 128;
  localparam int unsigned IMAGE_NUM   = 32;
  localparam int unsigned PIX_PER_IMG = IMAGE_SIZE * IMAGE_SIZE;
  localparam int unsigned CNT_W       = $clog2(PIX_PER_IMG + 1);
  localparam int unsigned IDX_W       = $clog2(IMAGE_NUM);
  localparam int unsigned PIX_W       = $clog2(PIX_PER_IMG);

  typedef enum logic [1:0] {
    COL_R = 2'd0,
    COL_G = 2'd1,
    COL_B = 2'd2
  } color_t;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DECIDE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/ise_pixel_dominant.sv
// Combinational dominant-channel picker for one RGB888 pixel.
// Ports:
//   i_pixel  in  24  {R[23:16], G[15:8], B[7:0]}
//   o_color  out     dominant colour; ties resolve red over green over blue
module ise_pixel_dominant
  import ise_pkg::*;
(
  input  logic [23:0] i_pixel,
  output color_t      o_color
);

  logic [7:0] w_r;
  logic [7:0] w_g;
  logic [7:0] w_b;

  assign w_r = i_pixel[23:16];
  assign w_g = i_pixel[15:8];
  assign w_b = i_pixel[7:0];

  always_comb begin
    o_color = COL_B;
    if (w_r >= w_g && w_r >= w_b) begin
      o_color = COL_R;
    end else if (w_g >= w_b) begin
      o_color = COL_G;
    end
  end

endmodule

// File: rtl/ise_color_classifier.sv
// Image Sorting Engine front end: counts red/green/blue-dominant pixels per
// image and emits one {colour, image index, winning count} record per image.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   pix_valid       pixel_in / image_in_index valid
//   image_in_index  image index of the pixel
//   pixel_in        {R, G, B} pixel
//   busy            pixel not accepted this cycle
//   rec_valid/ready record handshake
//   rec_color/image/count  record payload
//   idx_err         sticky: index changed inside an image
module ise_color_classifier
  import ise_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  input  logic [IDX_W-1:0] image_in_index,
  input  logic [23:0]      pixel_in,
  output logic             busy,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [1:0]       rec_color,
  output logic [IDX_W-1:0] rec_image,
  output logic [CNT_W-1:0] rec_count,
  output logic             idx_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PIX_W-1:0] r_pix_cnt;
  logic             r_p1_valid;
  logic             r_p1_last;
  logic [23:0]      r_p1_pixel;
  logic             r_p2_last;
  logic [CNT_W-1:0] r_cnt_r;
  logic [CNT_W-1:0] r_cnt_g;
  logic [CNT_W-1:0] r_cnt_b;
  logic [IDX_W-1:0] r_img_idx;
  logic             w_accept;
  logic             w_last;
  logic             w_load_rec;
  color_t           w_p1_color;
  color_t           w_win_col;
  logic [CNT_W-1:0] w_win_cnt;

  ise_pixel_dominant u_dom (
    .i_pixel (r_p1_pixel),
    .o_color (w_p1_color)
  );

  assign w_accept = pix_valid & ~busy;
  assign w_last   = (r_pix_cnt == PIX_W'(PIX_PER_IMG - 1));

  // busy covers the two-cycle P1/P2 drain after the last pixel, then
  // DECIDE and HOLD until the record is taken.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    w_load_rec  = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        busy = (r_p1_valid & r_p1_last) | r_p2_last;
        if (r_p2_last) w_state_nxt = ST_DECIDE;
      end
      ST_DECIDE: begin
        busy        = 1'b1;
        w_load_rec  = 1'b1;
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        busy = 1'b1;
        if (rec_valid & rec_ready) w_state_nxt = ST_ACCUM;
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  always_comb begin
    w_win_col = COL_B;
    w_win_cnt = r_cnt_b;
    if (r_cnt_r >= r_cnt_g && r_cnt_r >= r_cnt_b) begin
      w_win_col = COL_R;
      w_win_cnt = r_cnt_r;
    end else if (r_cnt_g >= r_cnt_b) begin
      w_win_col = COL_G;
      w_win_cnt = r_cnt_g;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_ACCUM;
      r_pix_cnt  <= '0;
      r_p1_valid <= 1'b0;
      r_p1_last  <= 1'b0;
      r_p1_pixel <= '0;
      r_p2_last  <= 1'b0;
      r_img_idx  <= '0;
      idx_err    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_p1_valid <= w_accept;
      r_p1_last  <= w_accept & w_last;
      r_p2_last  <= r_p1_valid & r_p1_last;
      if (w_accept) begin
        r_p1_pixel <= pixel_in;
        if (r_pix_cnt == '0) begin
          r_img_idx <= image_in_index;
        end else if (image_in_index != r_img_idx) begin
          idx_err <= 1'b1;
        end
        // Saturate on the last pixel; only DECIDE restarts the count.
        if (!w_last) r_pix_cnt <= r_pix_cnt + PIX_W'(1);
      end
      if (w_load_rec) r_pix_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_r <= '0;
      r_cnt_g <= '0;
      r_cnt_b <= '0;
    end else if (w_load_rec) begin
      r_cnt_r <= '0;
      r_cnt_g <= '0;
      r_cnt_b <= '0;
    end else if (r_p1_valid) begin
      case (w_p1_color)
        COL_R:   r_cnt_r <= r_cnt_r + CNT_W'(1);
        COL_G:   r_cnt_g <= r_cnt_g + CNT_W'(1);
        default: r_cnt_b <= r_cnt_b + CNT_W'(1);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rec_valid <= 1'b0;
      rec_color <= '0;
      rec_image <= '0;
      rec_count <= '0;
    end else if (w_load_rec) begin
      rec_valid <= 1'b1;
      rec_color <= w_win_col;
      rec_image <= r_img_idx;
      rec_count <= w_win_cnt;
    end else if (rec_valid & rec_ready) begin
      rec_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ise_color_classifier.sv
// Directed bench for ise_color_classifier: single-colour images, ties,
// split images, record back-pressure, a random image against a small
// reference model, mid-image reset and index-change detection.
module tb_ise_color_classifier;
  import ise_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             pix_valid;
  logic [IDX_W-1:0] image_in_index;
  logic [23:0]      pixel_in;
  logic             busy;
  logic             rec_valid;
  logic             rec_ready;
  logic [1:0]       rec_color;
  logic [IDX_W-1:0] rec_image;
  logic [CNT_W-1:0] rec_count;
  logic             idx_err;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  ise_color_classifier dut (
    .clk            (clk),
    .reset          (reset),
    .pix_valid      (pix_valid),
    .image_in_index (image_in_index),
    .pixel_in       (pixel_in),
    .busy           (busy),
    .rec_valid      (rec_valid),
    .rec_ready      (rec_ready),
    .rec_color      (rec_color),
    .rec_image      (rec_image),
    .rec_count      (rec_count),
    .idx_err        (idx_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel and hold it until the edge that accepts it.
  task automatic send(input logic [IDX_W-1:0] idx, input logic [23:0] px);
    int unsigned n = 0;
    pix_valid      = 1'b1;
    image_in_index = idx;
    pixel_in       = px;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (busy) check("send_busy_timeout", busy, 0);
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic wait_rec(input string tag);
    int unsigned n = 0;
    while (!rec_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_rec_valid"}, rec_valid, 1);
  endtask

  function automatic logic [1:0] model_dom(input logic [23:0] px);
    logic [7:0] r, g, b;
    r = px[23:16];
    g = px[15:8];
    b = px[7:0];
    if (r >= g && r >= b) return 2'd0;
    if (g >= b) return 2'd1;
    return 2'd2;
  endfunction

  // Channels drawn from {0,85,170,255} so ties are frequent.
  function automatic logic [23:0] rnd_px();
    logic [7:0] r, g, b;
    r = 8'($urandom_range(3) * 85);
    g = 8'($urandom_range(3) * 85);
    b = 8'($urandom_range(3) * 85);
    return {r, g, b};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] px;
    logic [23:0] first_px;
    int unsigned m_cnt [3];
    logic [1:0]  exp_col;
    int unsigned exp_cnt;
    logic        seen;

    reset = 1'b1; pix_valid = 1'b0; rec_ready = 1'b0;
    image_in_index = '0; pixel_in = '0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_rec_valid", rec_valid, 0);
    check("rst_rec_color", rec_color, 0);
    check("rst_rec_image", rec_image, 0);
    check("rst_rec_count", rec_count, 0);
    check("rst_idx_err", idx_err, 0);
    reset = 1'b0;
    tick();

    // Image 7 all red, latency of the record.
    rec_ready = 1'b1;
    for (int i = 0; i < 16384; i++) send(5'd7, 24'hFF0000);
    tick();
    check("t1_e1_rec_valid", rec_valid, 0);
    check("t1_e1_busy", busy, 1);
    tick();
    check("t1_e2_rec_valid", rec_valid, 0);
    check("t1_e2_busy", busy, 1);
    tick();
    check("t1_e3_rec_valid", rec_valid, 1);
    check("t1_color", rec_color, 0);
    check("t1_image", rec_image, 7);
    check("t1_count", rec_count, 16384);
    tick();
    check("t1_e4_rec_valid", rec_valid, 0);
    check("t1_e4_busy", busy, 0);

    // Image 3 grey: three-way tie goes to red.
    for (int i = 0; i < 16384; i++) send(5'd3, 24'h808080);
    wait_rec("t2");
    check("t2_color", rec_color, 0);
    check("t2_image", rec_image, 3);
    check("t2_count", rec_count, 16384);
    tick();

    // Image 12 half green / half blue, then record held with rec_ready low.
    rec_ready = 1'b0;
    for (int i = 0; i < 8192; i++) send(5'd12, 24'h00FF00);
    for (int i = 0; i < 8192; i++) send(5'd12, 24'h0000FF);
    wait_rec("t3");
    check("t3_color", rec_color, 1);
    check("t3_image", rec_image, 12);
    check("t3_count", rec_count, 8192);

    first_px       = rnd_px();
    pix_valid      = 1'b1;
    image_in_index = 5'd20;
    pixel_in       = first_px;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t4_hold_busy", busy, 1);
      check("t4_hold_valid", rec_valid, 1);
      check("t4_hold_color", rec_color, 1);
      check("t4_hold_image", rec_image, 12);
      check("t4_hold_count", rec_count, 8192);
    end
    rec_ready = 1'b1;
    tick();
    check("t4_released_valid", rec_valid, 0);
    check("t4_released_busy", busy, 0);

    // Image 20: random pixels with gaps, checked against the model.
    m_cnt = '{0, 0, 0};
    m_cnt[model_dom(first_px)]++;
    send(5'd20, first_px);
    for (int i = 1; i < 16384; i++) begin
      if ($urandom_range(31) == 0) repeat ($urandom_range(3, 1)) tick();
      px = rnd_px();
      m_cnt[model_dom(px)]++;
      send(5'd20, px);
    end
    if (m_cnt[0] >= m_cnt[1] && m_cnt[0] >= m_cnt[2]) begin
      exp_col = 2'd0; exp_cnt = m_cnt[0];
    end else if (m_cnt[1] >= m_cnt[2]) begin
      exp_col = 2'd1; exp_cnt = m_cnt[1];
    end else begin
      exp_col = 2'd2; exp_cnt = m_cnt[2];
    end
    rec_ready = 1'b0;
    wait_rec("t6");
    repeat (5) tick();
    check("t6_stall_valid", rec_valid, 1);
    check("t6_color", rec_color, 32'(exp_col));
    check("t6_image", rec_image, 20);
    check("t6_count", rec_count, exp_cnt);
    check("t6_idx_err", idx_err, 0);
    rec_ready = 1'b1;
    tick();

    // Image 9: reset after 5000 pixels discards it, replay all blue.
    for (int i = 0; i < 5000; i++) send(5'd9, 24'h0000FF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_valid", rec_valid, 0);
    check("t5_rst_busy", busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | rec_valid;
    end
    check("t5_no_rec", seen, 0);
    for (int i = 0; i < 16384; i++) send(5'd9, 24'h0000FF);
    wait_rec("t5");
    check("t5_color", rec_color, 2);
    check("t5_image", rec_image, 9);
    check("t5_count", rec_count, 16384);
    check("t5_idx_err", idx_err, 0);
    tick();

    // Index flip inside an image sets the sticky error.
    for (int i = 0; i < 10; i++) send(5'd4, 24'hFF0000);
    check("t7_idx_err_before", idx_err, 0);
    send(5'd5, 24'hFF0000);
    check("t7_idx_err_after", idx_err, 1);
    tick();
    check("t7_idx_err_sticky", idx_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
